// File: rtl/uart_receiver.sv
// 8N1 UART receiver with valid/ack handshake, framing-error pulse and sticky overrun.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            sync1_q, rx_s_q;
  logic            good_frame;
  logic            cnt_last, half_last;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
  logic            par_bad;
`endif

  assign cnt_last  = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign half_last = (cnt_q == CntW'(HALF_BIT - 1));
`ifdef UART_RX_PARITY_EN
  assign par_bad   = ^{shift_q, par_q};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    good_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        cnt_d = cnt_q + CntW'(1);
        if (half_last) begin
          cnt_d   = '0;
          // A high line at the start-bit midpoint is a glitch, not a frame.
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_last) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_last) begin
          cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad;
`endif
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            good_frame = !par_bad;
`else
            good_frame = 1'b1;
`endif
            // Returning at the stop midpoint lets an adjacent start bit be caught.
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (good_frame) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= RxD;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = (state_q != StIdle);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: scoreboard of sent bytes checked against received bytes,
// plus handshake, overrun, glitch, framing-error and mid-frame reset scenarios.
module tb_uart_receiver;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RxD;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RxD       (RxD),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         fe_cnt    = 0;
  int         rise_cyc  = 0;
  int         start_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    fe_cnt     <= fe_cnt + (frame_err ? 1 : 0);
    valid_prev <= rx_valid;
    if (rx_valid && !valid_prev) rise_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one full frame starting at the current negedge; stop_low holds the stop bit low
  // for that many bit periods before the line returns high.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input bit push);
    if (push) exp_q.push_back(d);
    RxD       = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RxD = ^d;
    repeat (CPB) @(negedge clk);
`endif
    if (stop_low > 0) begin
      RxD = 1'b0;
      repeat (stop_low * CPB) @(negedge clk);
    end
    RxD = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] e;
    int n = 0;
    while (rx_valid !== 1'b1 && n < 12 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk({tag, "_data"}, 32'(rx_data), 32'(e));
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},     32'(rx_data),   32'd0);
    chk({tag, "_valid"},    32'(rx_valid),  32'd0);
    chk({tag, "_busy"},     32'(rx_busy),   32'd0);
    chk({tag, "_frame"},    32'(frame_err), 32'd0);
    chk({tag, "_overrun"},  32'(overrun),   32'd0);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int fe_base;

    rst_n  = 1'b0;
    RxD    = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single clean frame with latency from start edge to rx_valid.
    send_frame(8'hA5, 0, 1'b1);
    check_rx("a5");
    lat = rise_cyc - start_cyc;
    chk("a5_latency", 32'(lat >= 152 && lat <= 156), 32'd1);
    chk("a5_no_frame_err", 32'(fe_cnt), 32'd0);
    chk("a5_busy_low", 32'(rx_busy), 32'd0);
    ack_pulse();
    chk("a5_ack_clears", 32'(rx_valid), 32'd0);

    // Back-to-back frames, acked while the next one is arriving.
    send_frame(8'h3C, 0, 1'b1);
    fork
      send_frame(8'hC3, 0, 1'b1);
      begin
        check_rx("b2b_3c");
        ack_pulse();
      end
    join
    check_rx("b2b_c3");
    chk("b2b_overrun", 32'(overrun), 32'd0);
    ack_pulse();

    // Overrun: second frame lands while the first is still unacked.
    send_frame(8'h11, 0, 1'b1);
    check_rx("ov_11");
    chk("ov_not_yet", 32'(overrun), 32'd0);
    send_frame(8'h22, 0, 1'b1);
    check_rx("ov_22");
    chk("ov_set", 32'(overrun), 32'd1);
    ack_pulse();
    chk("ov_ack_valid", 32'(rx_valid), 32'd0);
    chk("ov_ack_overrun", 32'(overrun), 32'd0);

    // Four-cycle low glitch must be rejected at the start-bit midpoint.
    busy_cnt = 0;
    for (int i = 0; i < 44; i++) begin
      if (rx_busy) busy_cnt++;
      RxD = (i < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    chk("glitch_seen", 32'(busy_cnt > 0), 32'd1);
    chk("glitch_busy_len", 32'(busy_cnt <= int'(HALF) + 3), 32'd1);
    chk("glitch_no_valid", 32'(rx_valid), 32'd0);
    chk("glitch_idle", 32'(rx_busy), 32'd0);

    // Stop bit held low for three periods: one frame_err, no retrigger during the break.
    fe_base = fe_cnt;
    send_frame(8'h55, 3, 1'b0);
    repeat (12 * CPB) @(negedge clk);
    chk("fe_single_pulse", 32'(fe_cnt - fe_base), 32'd1);
    chk("fe_data_kept", 32'(rx_data), 32'h22);
    chk("fe_no_valid", 32'(rx_valid), 32'd0);
    chk("fe_idle", 32'(rx_busy), 32'd0);

    // Reset asserted while bit 3 of 8'hF0 is on the line.
    fork
      send_frame(8'hF0, 0, 1'b0);
      begin
        repeat (4 * CPB + HALF) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
      end
    join
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h0F, 0, 1'b1);
    check_rx("after_rst_0f");
    chk("after_rst_overrun", 32'(overrun), 32'd0);
    ack_pulse();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
